uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; BIT_CYC = CLK_HZ/BAUD (integer division; 868 at defaults).
REQ-003 Parameter DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-004 CLK_100MHz  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 UART_RX  input  1  serial line, idle high, 8N1 LSB-first (8E1 with REQ-027), asynchronous to clock.
REQ-007 clear  input  1  pop strobe; one entry popped per cycle held high.
REQ-008 out  output  16  status/data word, layout per REQ-017.
REQ-009 rx_ready  output  1  high while FIFO non-empty.
REQ-010 overrun  output  1  sticky, set when a byte is dropped because the FIFO is full.

Function
REQ-011 UART_RX passes a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-012 Receive FSM states: IDLE, START, DATA, (PARITY per REQ-027), STOP, WAIT_HIGH.
REQ-013 IDLE: rxs==0 -> START, bit counter cleared to 0.
REQ-014 START: at count BIT_CYC/2, rxs==0 -> DATA, counter restarts; rxs==1 -> IDLE, no entry, no flag (glitch rejection).
REQ-015 DATA: sample rxs every BIT_CYC cycles into bit[i], i=0..7 LSB first; after bit 7 -> STOP (or PARITY).
REQ-016 STOP: sample after BIT_CYC; push {ferr, byte}, ferr = ~rxs; rxs==1 -> IDLE same cycle (back-to-back frames, no gap); rxs==0 -> WAIT_HIGH; WAIT_HIGH -> IDLE on first rxs==1.
REQ-017 out[15] = 1 when FIFO empty; out[14:10] = 0; out[9] = parity error of head; out[8] = framing error of head; out[7:0] = head byte; when empty, out[14:0] = 0.
REQ-018 Write latency: entry visible on out/rx_ready the cycle after the STOP sample edge.
REQ-019 Pop: clear high with FIFO non-empty advances head; next head (or empty word) visible next cycle.
REQ-020 clear with FIFO empty: no effect, no pointer motion.
REQ-021 Push with FIFO full and no same-cycle pop: byte dropped, contents unchanged, overrun <= 1.
REQ-022 Push and pop same cycle when full: both performed, count unchanged, overrun unchanged.
REQ-023 Push and pop same cycle when empty: push performed, pop ignored; count becomes 1.
REQ-024 overrun cleared by any clear pulse unless a drop occurs in the same cycle (set wins).
REQ-025 Pointers wrap modulo DEPTH; count width log2(DEPTH)+1; FIFO order strictly first-in first-out.

Reset
REQ-026 reset_n low, at any time including mid-frame: FSM -> IDLE, counters 0, FIFO empty, synchronizer 1s, rx_ready = 0, overrun = 0, out = 16'h8000; a partial frame is discarded; first frame recognized only after a falling edge seen after release.

Configuration
REQ-027 UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit; out[9] = 1 when XOR(byte, parity bit) != 0; frame = 11 bits.
REQ-028 UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frame, out[9] tied 0; all other behaviour identical.

Verification
REQ-029 Reset, idle line -> out = 16'h8000, rx_ready = 0, overrun = 0.
REQ-030 Frame 8'hA5 at 868 cycles/bit -> out = 16'h00A5, rx_ready = 1 within 1 cycle of mid-stop sample; clear 1 cycle -> out = 16'h8000.
REQ-031 Five back-to-back frames 8'h01..8'h05, DEPTH = 4, no clear -> overrun = 1; pops return 01,02,03,04 then out = 16'h8000.
REQ-032 Frame 8'h3C with stop bit held low 2 bit times -> out = 16'h013C; next frame 8'h41 received correctly after line returns high.
REQ-033 300-cycle low pulse on idle line -> no entry, out stays 16'h8000; reset_n pulsed mid-DATA of frame 8'hFF -> FIFO empty, following frame 8'h12 -> out = 16'h0012.
REQ-034 With UART_RX_PARITY_EN: frame 8'h07 with parity bit 0 -> out = 16'h0207; with parity bit 1 -> out = 16'h0007.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1/8E1 receiver with a small receive FIFO and status word
//
// Ports:
//   CLK_100MHz  system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   UART_RX     serial line, idle high, LSB first, asynchronous to the clock
//   clear       pop strobe; one entry popped per cycle while high
//   out[15:0]   {empty, 5'b0, parity_err, framing_err, byte} of the FIFO head (16'h8000 when empty)
//   rx_ready    FIFO non-empty
//   overrun     sticky; set when a received byte is dropped on a full FIFO, cleared by clear
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit (11-bit frame).

module uart_rx_fifo #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic        CLK_100MHz,
    input  logic        reset_n,
    input  logic        UART_RX,
    input  logic        clear,
    output logic [15:0] out,
    output logic        rx_ready,
    output logic        overrun
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam int AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic [1:0]       sync_q, sync_d;
    logic             rxs;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             push;
    logic [9:0]       push_data;

    logic [9:0]  mem_q [DEPTH];
    logic [9:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          empty, full, do_pop, do_push, drop;

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
    assign sync_d = {sync_q[0], UART_RX};
    assign rxs    = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                // Mid-start re-check rejects glitches shorter than half a bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    push  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    push_data = {(^shift_q) ^ par_q, ~rxs, shift_q};
`else
                    push_data = {1'b0, ~rxs, shift_q};
`endif
                    // Going straight to IDLE lets a back-to-back start bit be caught.
                    state_d = rxs ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = clear && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) rd_d = rd_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + (AW + 1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) overrun_d = 1'b1;
        else if (clear) overrun_d = 1'b0;
        else overrun_d = overrun_q;
    end

    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        out = 16'h8000;
        if (!empty) out = {6'b0, mem_q[rd_q]};
    end

    assign rx_ready = !empty;
    assign overrun  = overrun_q;

endmodule
